// File: rtl/pb_emulator_if.sv
// Command/status bundle between a push-button emulator and whoever drives it.
// The master issues go/hold/bounce_en/abort; the slave returns PB/busy/done.
interface pb_emulator_if;
    logic        go;
    logic [15:0] hold;
    logic        bounce_en;
    logic        abort;
    logic        PB;
    logic        busy;
    logic        done;

    modport master (output go, hold, bounce_en, abort, input PB, busy, done);
    modport slave  (input go, hold, bounce_en, abort, output PB, busy, done);
endinterface

// File: rtl/pb_emulator.sv
// Emulated active-low push button: press bounce, programmable hold, release bounce.
// Outputs are registered and change on the go-accepting edge; go is ignored while busy (not queued).
module pb_emulator #(
    parameter int BOUNCE_CYCLES   = 4,
    parameter int BOUNCE_GLITCHES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    pb_emulator_if.slave bus
);
    localparam int SEG_W = $clog2(BOUNCE_CYCLES + 1);
    localparam int GLT_W = $clog2(2 * BOUNCE_GLITCHES + 1);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(BOUNCE_CYCLES - 1);
    localparam logic [GLT_W-1:0] GLT_LAST = GLT_W'(2 * BOUNCE_GLITCHES - 1);

    typedef enum logic [1:0] {IDLE, P_BNC, HOLD, R_BNC} state_t;

    state_t           state_q, state_d;
    logic [15:0]      hold_q, hold_d;
    logic [15:0]      hcnt_q, hcnt_d;
    logic             ben_q, ben_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [GLT_W-1:0] glt_q, glt_d;
    logic             pb_q, pb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             seg_end;

    assign seg_end = (seg_q == SEG_LAST);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ben_d   = ben_q;
        hcnt_d  = '0;
        seg_d   = '0;
        glt_d   = '0;
        done_d  = 1'b0;
        pb_d    = 1'b1;
        busy_d  = 1'b0;

        // Counters default to zero so every state change starts them fresh.
        unique case (state_q)
            IDLE: begin
                if (bus.go && !bus.abort) begin
                    hold_d  = (bus.hold == 16'd0) ? 16'd1 : bus.hold;
                    ben_d   = bus.bounce_en;
                    state_d = bus.bounce_en ? P_BNC : HOLD;
                end
            end
            P_BNC, R_BNC: begin
                if (seg_end && glt_q == GLT_LAST) begin
                    state_d = (state_q == P_BNC) ? HOLD : IDLE;
                    done_d  = (state_q == R_BNC);
                end else if (seg_end) begin
                    glt_d = glt_q + 1'b1;
                end else begin
                    seg_d = seg_q + 1'b1;
                    glt_d = glt_q;
                end
            end
            HOLD: begin
                if (hcnt_q == hold_q - 16'd1) begin
                    state_d = ben_q ? R_BNC : IDLE;
                    done_d  = !ben_q;
                end else begin
                    hcnt_d = hcnt_q + 16'd1;
                end
            end
        endcase

        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
            hcnt_d  = '0;
            seg_d   = '0;
            glt_d   = '0;
        end

        // Output levels are derived from the next state so they register on the same edge.
        busy_d = (state_d != IDLE);
        unique case (state_d)
            IDLE:    pb_d = 1'b1;
            P_BNC:   pb_d = glt_d[0];
            HOLD:    pb_d = 1'b0;
            R_BNC:   pb_d = ~glt_d[0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            ben_q   <= 1'b0;
            hcnt_q  <= '0;
            seg_q   <= '0;
            glt_q   <= '0;
            pb_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ben_q   <= ben_d;
            hcnt_q  <= hcnt_d;
            seg_q   <= seg_d;
            glt_q   <= glt_d;
            pb_q    <= pb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.PB   = pb_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_pb_emulator.sv
// Scoreboard bench for pb_emulator: expected {PB,busy,done} per cycle is queued when go is driven.
module tb_pb_emulator;
    localparam int B = 4;
    localparam int G = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pb_emulator_if bus();

    pb_emulator #(.BOUNCE_CYCLES(B), .BOUNCE_GLITCHES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [2:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [2:0] obs();
        return {bus.PB, bus.busy, bus.done};
    endfunction

    // Expected per-cycle {PB,busy,done} after the accepting edge, through the idle cycle after done.
    task automatic push_seq(input int h, input bit ben);
        int hh;
        hh = (h == 0) ? 1 : h;
        if (ben)
            for (int s = 0; s < 2 * G; s++)
                for (int i = 0; i < B; i++)
                    exp_q.push_back({(s % 2 == 1), 1'b1, 1'b0});
        for (int i = 0; i < hh; i++) exp_q.push_back(3'b010);
        if (ben)
            for (int s = 0; s < 2 * G; s++)
                for (int i = 0; i < B; i++)
                    exp_q.push_back({(s % 2 == 0), 1'b1, 1'b0});
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b100);
    endtask

    task automatic start(input int h, input bit ben);
        bus.go        = 1'b1;
        bus.hold      = 16'(h);
        bus.bounce_en = ben;
        push_seq(h, ben);
    endtask

    task automatic test_reset;
        logic [2:0] e, o;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 o = obs();
        n_checks++;
        if (o !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected 100", o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) exp_q.push_back(3'b100);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %b expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_no_bounce;
        logic [2:0] e, o;
        start(5, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (c == 0) bus.go = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL no_bounce cycle %0d: got %b expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_bounce;
        logic [2:0] e, o;
        int busy_cnt, done_at;
        busy_cnt = 0;
        done_at  = -1;
        start(10, 1'b1);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (c == 0) bus.go = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            if (o[1]) busy_cnt++;
            if (o[0] && done_at < 0) done_at = c;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: got %b expected %b", c, o, e);
            end
        end
        n_checks++;
        if (busy_cnt != 4 * G * B + 10) begin
            n_fail++;
            $display("FAIL bounce_busy_len: got %0d expected %0d", busy_cnt, 4 * G * B + 10);
        end
        n_checks++;
        if (done_at != 4 * G * B + 10) begin
            n_fail++;
            $display("FAIL bounce_done_edge: got k+%0d expected k+%0d", done_at, 4 * G * B + 10);
        end
    endtask

    task automatic test_zero_hold;
        logic [2:0] e, o;
        start(0, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (c == 0) bus.go = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL zero_hold cycle %0d: got %b expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_ignored_go;
        logic [2:0] e, o;
        start(6, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (c == 0) bus.go = 1'b0;
            if (c == 2) begin
                bus.go        = 1'b1;
                bus.hold      = 16'd3;
                bus.bounce_en = 1'b1;
            end
            if (c == 3) bus.go = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ignored_go cycle %0d: got %b expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_abort;
        logic [2:0] e, o;
        bus.go        = 1'b1;
        bus.hold      = 16'd20;
        bus.bounce_en = 1'b0;
        repeat (3) exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        push_seq(2, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (c == 0) bus.go = 1'b0;
            if (c == 2) bus.abort = 1'b1;
            if (c == 3) begin
                bus.abort = 1'b0;
                bus.go    = 1'b1;
                bus.hold  = 16'd2;
            end
            if (c == 4) bus.go = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort cycle %0d: got %b expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_bounce;
        logic [2:0] e, o;
        start(2, 1'b1);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (c == 0) bus.go = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_mid_seq cycle %0d: got %b expected %b", c, o, e);
            end
        end
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1 o = obs();
        n_checks++;
        if (o !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %b expected 100", o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) exp_q.push_back(3'b100);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_mid_after cycle %0d: got %b expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_go_abort_idle;
        logic [2:0] e, o;
        bus.go        = 1'b1;
        bus.abort     = 1'b1;
        bus.hold      = 16'd4;
        bus.bounce_en = 1'b0;
        repeat (4) exp_q.push_back(3'b100);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.go    = 1'b0;
                bus.abort = 1'b0;
            end
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL go_abort_idle cycle %0d: got %b expected %b", c, o, e);
            end
        end
    endtask

    initial begin
        bus.go        = 1'b0;
        bus.hold      = 16'd0;
        bus.bounce_en = 1'b0;
        bus.abort     = 1'b0;
        test_reset();
        test_no_bounce();
        test_bounce();
        test_zero_hold();
        test_ignored_go();
        test_abort();
        test_reset_mid_bounce();
        test_go_abort_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
        $fatal(1);
    end
endmodule
